// File: rtl/ppu_px_fifo_if.sv
// Pixel FIFO bus: BG row push, sprite row merge, fine-scroll drop, head pop
// and flush. The FIFO is the slave; the fetchers and pixel stage are the master.
interface ppu_px_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int ROW_W  = 8,
    parameter int ATTR_W = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [ROW_W-1:0]  push_plane0;
    logic [ROW_W-1:0]  push_plane1;
    logic [ATTR_W-1:0] push_attr;
    logic              push_xflip;
    logic              merge_valid;
    logic              merge_ready;
    logic [ROW_W-1:0]  merge_plane0;
    logic [ROW_W-1:0]  merge_plane1;
    logic [ATTR_W-1:0] merge_attr;
    logic              merge_xflip;
    logic              drop_valid;
    logic [2:0]        drop_n;
    logic              pop;
    logic              pop_ack;
    logic              px_valid;
    logic [1:0]        px_color;
    logic [ATTR_W-1:0] px_attr;
    logic              px_src;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush,
        output push_valid, push_plane0, push_plane1, push_attr, push_xflip,
        input  push_ready,
        output merge_valid, merge_plane0, merge_plane1, merge_attr, merge_xflip,
        input  merge_ready,
        output drop_valid, drop_n,
        output pop,
        input  pop_ack,
        input  px_valid, px_color, px_attr, px_src, count
    );

    modport slave (
        input  flush,
        input  push_valid, push_plane0, push_plane1, push_attr, push_xflip,
        output push_ready,
        input  merge_valid, merge_plane0, merge_plane1, merge_attr, merge_xflip,
        output merge_ready,
        input  drop_valid, drop_n,
        input  pop,
        output pop_ack,
        output px_valid, px_color, px_attr, px_src, count
    );
endinterface

// File: rtl/ppu_px_fifo.sv
// PPU pixel FIFO: circular buffer of {src, attr, color} pixels. BG rows are
// expanded from bitplanes at the tail, sprite rows are merged over the first
// ROW_W head entries, and the head can be popped, dropped (fine scroll) or
// flushed. Head outputs are combinational from the head entry.
module ppu_px_fifo #(
    parameter int DEPTH  = 16,
    parameter int ROW_W  = 8,
    parameter int ATTR_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    ppu_px_fifo_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;

    logic [1:0]        r_color [DEPTH];
    logic [ATTR_W-1:0] r_attr  [DEPTH];
    logic              r_src   [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_live;
    logic              w_empty;
    logic              w_push_ready;
    logic              w_merge_ready;
    logic              w_push_acc;
    logic              w_merge_acc;
    logic              w_drop_acc;
    logic              w_pop_acc;
    logic [CNT_W-1:0]  w_drop_n;
    logic [CNT_W-1:0]  w_removed;
    logic [CNT_W-1:0]  w_add;
    logic [PTR_W-1:0]  w_mrg_idx  [ROW_W];
    logic [1:0]        w_mrg_col  [ROW_W];
    logic              w_mrg_we   [ROW_W];
    logic [PTR_W-1:0]  w_push_idx [ROW_W];
    logic [1:0]        w_push_col [ROW_W];

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Colour of pixel k (k = 0 leaves first) of a tile row.
    function automatic logic [1:0] f_px(input logic [ROW_W-1:0] p0,
                                        input logic [ROW_W-1:0] p1,
                                        input logic xf, input int k);
        logic [BIT_W-1:0] b;
        b = xf ? BIT_W'(k) : BIT_W'(ROW_W - 1 - k);
        return {p1[b], p0[b]};
    endfunction

    // rst and flush both squash every same-cycle transfer.
    assign w_live        = !rst && !bus.flush;
    assign w_empty       = (r_count == '0);
    assign w_push_ready  = (int'(r_count) <= DEPTH - ROW_W);
    assign w_merge_ready = (int'(r_count) >= ROW_W);
    assign w_push_acc    = w_live && bus.push_valid && w_push_ready;
    assign w_merge_acc   = w_live && bus.merge_valid && w_merge_ready;
    assign w_drop_acc    = w_live && bus.drop_valid && !w_merge_acc;
    assign w_pop_acc     = w_live && bus.pop && !w_empty && !w_merge_acc && !bus.drop_valid;
    assign w_drop_n      = CNT_W'(bus.drop_n);
    assign w_add         = w_push_acc ? CNT_W'(ROW_W) : '0;

    // Entries leaving the head this cycle: clamped drop, or a single pop.
    always_comb begin
        w_removed = '0;
        if (w_drop_acc)
            w_removed = (w_drop_n > r_count) ? r_count : w_drop_n;
        else if (w_pop_acc)
            w_removed = CNT_W'(1);
    end

    // Per-pixel write addresses, colours and merge enables for both row paths.
    always_comb begin
        for (int k = 0; k < ROW_W; k++) begin
            w_mrg_idx[k]  = f_wrap(r_head, k);
            w_mrg_col[k]  = f_px(bus.merge_plane0, bus.merge_plane1, bus.merge_xflip, k);
            w_mrg_we[k]   = w_merge_acc && (w_mrg_col[k] != 2'd0) && !r_src[w_mrg_idx[k]] &&
                            !(bus.merge_attr[ATTR_W-1] && (r_color[w_mrg_idx[k]] != 2'd0));
            w_push_idx[k] = f_wrap(r_tail, k);
            w_push_col[k] = f_px(bus.push_plane0, bus.push_plane1, bus.push_xflip, k);
        end
    end

    // Pixel storage: merge rewrites occupied head entries, push fills free tail
    // entries, so the two never target the same slot.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ROW_W; k++) begin
            if (w_mrg_we[k]) begin
                r_color[w_mrg_idx[k]] <= w_mrg_col[k];
                r_attr[w_mrg_idx[k]]  <= bus.merge_attr;
                r_src[w_mrg_idx[k]]   <= 1'b1;
            end
            if (w_push_acc) begin
                r_color[w_push_idx[k]] <= w_push_col[k];
                r_attr[w_push_idx[k]]  <= bus.push_attr;
                r_src[w_push_idx[k]]   <= 1'b0;
            end
        end
    end

    // Head/tail pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            r_head  <= f_wrap(r_head, int'(w_removed));
            if (w_push_acc)
                r_tail <= f_wrap(r_tail, ROW_W);
            r_count <= r_count + w_add - w_removed;
        end
    end

    assign bus.push_ready  = rst || w_push_ready;
    assign bus.merge_ready = !rst && w_merge_ready;
    assign bus.pop_ack     = w_pop_acc;
    assign bus.px_valid    = !rst && !w_empty;
    assign bus.px_color    = (rst || w_empty) ? 2'd0 : r_color[r_head];
    assign bus.px_attr     = (rst || w_empty) ? '0 : r_attr[r_head];
    assign bus.px_src      = (rst || w_empty) ? 1'b0 : r_src[r_head];
    assign bus.count       = rst ? '0 : r_count;
endmodule

// File: tb/tb_ppu_px_fifo.sv
// Bench for ppu_px_fifo: vector table of directed cycles, hand sequences for
// flush and mid-stream reset, then random traffic against a queue model.
module tb_ppu_px_fifo;
    localparam int DEPTH  = 16;
    localparam int ROW_W  = 8;
    localparam int ATTR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ppu_px_fifo_if #(.DEPTH(DEPTH), .ROW_W(ROW_W), .ATTR_W(ATTR_W)) bus ();

    ppu_px_fifo #(.DEPTH(DEPTH), .ROW_W(ROW_W), .ATTR_W(ATTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       flush;
        logic       push_v;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [1:0] pattr;
        logic       pxf;
        logic       merge_v;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [1:0] mattr;
        logic       mxf;
        logic       drop_v;
        logic [2:0] drop_n;
        logic       pop;
    } stim_t;

    typedef struct {
        int cnt;
        int vld;
        int col;
        int attr;
        int src;
        int ack;
        int pr;
        int mr;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        int col;
        int attr;
        int src;
    } ent_t;

    int   checks = 0;
    int   failures = 0;
    ent_t mq[$];
    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(int cnt, int vld, int col, int attr, int src,
                                    int ack, int pr, int mr);
        exp_t e;
        e.cnt = cnt; e.vld = vld; e.col = col; e.attr = attr;
        e.src = src; e.ack = ack; e.pr = pr; e.mr = mr;
        return e;
    endfunction

    function automatic stim_t st_idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t st_push(logic [7:0] p0, logic [7:0] p1, logic [1:0] a, logic xf);
        stim_t s;
        s = st_idle();
        s.push_v = 1'b1; s.p0 = p0; s.p1 = p1; s.pattr = a; s.pxf = xf;
        return s;
    endfunction

    function automatic stim_t st_merge(logic [7:0] m0, logic [7:0] m1, logic [1:0] a);
        stim_t s;
        s = st_idle();
        s.merge_v = 1'b1; s.m0 = m0; s.m1 = m1; s.mattr = a;
        return s;
    endfunction

    function automatic stim_t st_pop();
        stim_t s;
        s = st_idle();
        s.pop = 1'b1;
        return s;
    endfunction

    function automatic stim_t st_drop(logic [2:0] n);
        stim_t s;
        s = st_idle();
        s.drop_v = 1'b1; s.drop_n = n;
        return s;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic apply(input stim_t s);
        rst              = s.rst;
        bus.flush        = s.flush;
        bus.push_valid   = s.push_v;
        bus.push_plane0  = s.p0;
        bus.push_plane1  = s.p1;
        bus.push_attr    = s.pattr;
        bus.push_xflip   = s.pxf;
        bus.merge_valid  = s.merge_v;
        bus.merge_plane0 = s.m0;
        bus.merge_plane1 = s.m1;
        bus.merge_attr   = s.mattr;
        bus.merge_xflip  = s.mxf;
        bus.drop_valid   = s.drop_v;
        bus.drop_n       = s.drop_n;
        bus.pop          = s.pop;
    endtask

    // Spec colour of pixel k from a pair of planes.
    function automatic int row_px(logic [7:0] p0, logic [7:0] p1, logic xf, int k);
        logic [7:0] a;
        logic [7:0] b;
        int bit_i;
        a = p0; b = p1;
        bit_i = xf ? k : ROW_W - 1 - k;
        return 2 * int'(b[bit_i]) + int'(a[bit_i]);
    endfunction

    function automatic exp_t model_out(stim_t s);
        exp_t e;
        int   n;
        bit   merge_acc;
        n = mq.size();
        e = mk_exp(0, 0, 0, 0, 0, 0, 1, 0);
        if (s.rst) return e;
        e.cnt = n;
        e.vld = (n != 0);
        if (n != 0) begin
            e.col  = mq[0].col;
            e.attr = mq[0].attr;
            e.src  = mq[0].src;
        end
        e.pr = (n <= DEPTH - ROW_W);
        e.mr = (n >= ROW_W);
        merge_acc = s.merge_v && (n >= ROW_W);
        e.ack = s.pop && (n != 0) && !merge_acc && !s.drop_v && !s.flush;
        return e;
    endfunction

    task automatic model_step(input stim_t s);
        int   n;
        int   c;
        int   rm;
        bit   merge_acc;
        bit   push_acc;
        ent_t en;
        n = mq.size();
        if (s.rst || s.flush) begin
            mq.delete();
            return;
        end
        merge_acc = s.merge_v && (n >= ROW_W);
        push_acc  = s.push_v && (n <= DEPTH - ROW_W);
        if (merge_acc) begin
            for (int k = 0; k < ROW_W; k++) begin
                c = row_px(s.m0, s.m1, s.mxf, k);
                if (c != 0 && mq[k].src == 0 && !(s.mattr[1] && mq[k].col != 0)) begin
                    mq[k].col = c; mq[k].attr = int'(s.mattr); mq[k].src = 1;
                end
            end
        end else if (s.drop_v) begin
            rm = (int'(s.drop_n) < n) ? int'(s.drop_n) : n;
            repeat (rm) void'(mq.pop_front());
        end else if (s.pop && n != 0) begin
            void'(mq.pop_front());
        end
        if (push_acc) begin
            for (int k = 0; k < ROW_W; k++) begin
                en.col = row_px(s.p0, s.p1, s.pxf, k);
                en.attr = int'(s.pattr);
                en.src = 0;
                mq.push_back(en);
            end
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".count"},       int'(bus.count),       e.cnt);
        chk({tag, ".px_valid"},    int'(bus.px_valid),    e.vld);
        chk({tag, ".px_color"},    int'(bus.px_color),    e.col);
        chk({tag, ".px_attr"},     int'(bus.px_attr),     e.attr);
        chk({tag, ".px_src"},      int'(bus.px_src),      e.src);
        chk({tag, ".pop_ack"},     int'(bus.pop_ack),     e.ack);
        chk({tag, ".push_ready"},  int'(bus.push_ready),  e.pr);
        chk({tag, ".merge_ready"}, int'(bus.merge_ready), e.mr);
    endtask

    // One cycle: drive after the falling edge, sample 1 ns later, then advance the model.
    task automatic run_cycle(input stim_t s, input bit has_exp, input exp_t e, input string tag);
        exp_t m;
        @(negedge clk);
        apply(s);
        #1;
        m = model_out(s);
        check_out({tag, "_mdl"}, m);
        if (has_exp) check_out({tag, "_vec"}, e);
        model_step(s);
    endtask

    initial begin
        stim_t s;
        exp_t  none;
        none = mk_exp(0, 0, 0, 0, 0, 0, 0, 0);
        s = st_idle();
        s.rst = 1'b1;
        apply(s);

        // reset
        add(s, mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        // one row out in order 3,3,1,1,2,2,0,0
        add(st_push(8'hF0, 8'hCC, 2'd0, 1'b0), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        add(st_pop(), mk_exp(8, 1, 3, 0, 0, 1, 1, 1));
        add(st_pop(), mk_exp(7, 1, 3, 0, 0, 1, 1, 0));
        add(st_pop(), mk_exp(6, 1, 1, 0, 0, 1, 1, 0));
        add(st_pop(), mk_exp(5, 1, 1, 0, 0, 1, 1, 0));
        add(st_pop(), mk_exp(4, 1, 2, 0, 0, 1, 1, 0));
        add(st_pop(), mk_exp(3, 1, 2, 0, 0, 1, 1, 0));
        add(st_pop(), mk_exp(2, 1, 0, 0, 0, 1, 1, 0));
        add(st_pop(), mk_exp(1, 1, 0, 0, 0, 1, 1, 0));
        add(st_idle(), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        // fill to DEPTH; push at full with a pop is still refused
        add(st_push(8'hF0, 8'hCC, 2'd0, 1'b0), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        add(st_push(8'hF0, 8'hCC, 2'd0, 1'b0), mk_exp(8, 1, 3, 0, 0, 0, 1, 1));
        s = st_push(8'hF0, 8'hCC, 2'd0, 1'b0); s.pop = 1'b1;
        add(s, mk_exp(16, 1, 3, 0, 0, 1, 0, 1));
        add(st_drop(3'd7), mk_exp(15, 1, 3, 0, 0, 0, 0, 1));
        // push + pop at count 8: both applied
        s = st_push(8'hF0, 8'hCC, 2'd0, 1'b0); s.pop = 1'b1;
        add(s, mk_exp(8, 1, 3, 0, 0, 1, 1, 1));
        s = st_idle(); s.flush = 1'b1;
        add(s, mk_exp(15, 1, 3, 0, 0, 0, 0, 1));
        // sprite merge, priority bit, earlier sprite wins, merge stalls pop
        add(st_push(8'hFF, 8'h00, 2'd0, 1'b0), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        add(st_merge(8'h00, 8'h81, 2'b01), mk_exp(8, 1, 1, 0, 0, 0, 1, 1));
        add(st_merge(8'h00, 8'hFF, 2'b11), mk_exp(8, 1, 2, 1, 1, 0, 1, 1));
        s = st_merge(8'h81, 8'h81, 2'b00); s.pop = 1'b1;
        add(s, mk_exp(8, 1, 2, 1, 1, 0, 1, 1));
        add(st_pop(), mk_exp(8, 1, 2, 1, 1, 1, 1, 1));
        for (int k = 1; k < 7; k++)
            add(st_pop(), mk_exp(8 - k, 1, 1, 0, 0, 1, 1, 0));
        add(st_pop(), mk_exp(1, 1, 2, 1, 1, 1, 1, 0));
        add(st_idle(), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        // xflip and drop clamping
        add(st_push(8'h01, 8'h00, 2'd0, 1'b1), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        s = st_drop(3'd3); s.pop = 1'b1;
        add(s, mk_exp(8, 1, 1, 0, 0, 0, 1, 1));
        add(st_drop(3'd3), mk_exp(5, 1, 0, 0, 0, 0, 1, 0));
        add(st_drop(3'd7), mk_exp(2, 1, 0, 0, 0, 0, 1, 0));
        add(st_idle(), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        // drop held off by a same-cycle merge
        add(st_push(8'hFF, 8'h00, 2'd0, 1'b0), mk_exp(0, 0, 0, 0, 0, 0, 1, 0));
        s = st_merge(8'h80, 8'h00, 2'b00); s.drop_v = 1'b1; s.drop_n = 3'd5; s.pop = 1'b1;
        add(s, mk_exp(8, 1, 1, 0, 0, 0, 1, 1));
        add(st_idle(), mk_exp(8, 1, 1, 0, 1, 0, 1, 1));

        for (int i = 0; i < vecs.size(); i++)
            run_cycle(vecs[i].s, 1'b1, vecs[i].e, $sformatf("vec%0d", i));

        // flush discards a same-cycle push and pop
        s = st_push(8'hFF, 8'h00, 2'd0, 1'b0); s.flush = 1'b1; s.pop = 1'b1;
        run_cycle(s, 1'b1, mk_exp(8, 1, 1, 0, 1, 0, 1, 1), "flush0");
        run_cycle(st_idle(), 1'b1, mk_exp(0, 0, 0, 0, 0, 0, 1, 0), "flush1");

        // reset in the middle of traffic
        run_cycle(st_push(8'hFF, 8'h00, 2'd3, 1'b0), 1'b1, mk_exp(0, 0, 0, 0, 0, 0, 1, 0), "rstm0");
        run_cycle(st_pop(), 1'b1, mk_exp(8, 1, 1, 3, 0, 1, 1, 1), "rstm1");
        s = st_push(8'hAA, 8'h55, 2'd1, 1'b0); s.pop = 1'b1; s.rst = 1'b1;
        run_cycle(s, 1'b1, mk_exp(0, 0, 0, 0, 0, 0, 1, 0), "rstm2");
        run_cycle(st_idle(), 1'b1, mk_exp(0, 0, 0, 0, 0, 0, 1, 0), "rstm3");

        // random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(0, 299) == 0);
            s.flush   = ($urandom_range(0, 39) == 0);
            s.push_v  = 1'($urandom_range(0, 1));
            s.p0      = 8'($urandom);
            s.p1      = 8'($urandom);
            s.pattr   = 2'($urandom_range(0, 3));
            s.pxf     = 1'($urandom_range(0, 1));
            s.merge_v = ($urandom_range(0, 4) == 0);
            s.m0      = 8'($urandom);
            s.m1      = 8'($urandom);
            s.mattr   = 2'($urandom_range(0, 3));
            s.mxf     = 1'($urandom_range(0, 1));
            s.drop_v  = ($urandom_range(0, 9) == 0);
            s.drop_n  = 3'($urandom_range(0, 7));
            s.pop     = ($urandom_range(0, 2) != 0);
            run_cycle(s, 1'b0, none, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
